// File: rtl/ahb_bus_matrix_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bus_matrix_arbiter
// Description : Round-robin arbiter for one AHB bus-matrix output stage.
//               Several input stages share one slave port. The arbiter picks
//               the owner of the output address phase and keeps that owner
//               through fixed-length bursts, locked sequences and BUSY beats
//               of undefined-length bursts. It also tracks the data-phase
//               owner, which the output mux uses to steer write data and
//               responses.
//
// Ports       : HCLK          AHB clock
//               HRESET        synchronous active-high reset
//               REQ           per-port request for this slave
//               LOCK          per-port HMASTLOCK of the pending/current transfer
//               HTRANSM       HTRANS currently driven on the output stage
//               HBURSTM       HBURST currently driven on the output stage
//               HREADYM       HREADY from the slave (1 = address phase accepted)
//               ADDR_IN_PORT  port that owns the address phase
//               NO_PORT       no port owns the address phase (mux drives IDLE)
//               DATA_IN_PORT  port that owns the data phase
//               DATA_VALID    data phase is an active NONSEQ/SEQ transfer
//               HMASTLOCKM    lock forwarded to the slave
//
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bus_matrix_arbiter #(
    parameter int NUM_PORTS = 4,   // requesting input stages, 2..8
    parameter int IDX_W     = 2    // port index width, 2**IDX_W >= NUM_PORTS
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] REQ,
    input  logic [NUM_PORTS-1:0] LOCK,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HREADYM,
    output logic [IDX_W-1:0]     ADDR_IN_PORT,
    output logic                 NO_PORT,
    output logic [IDX_W-1:0]     DATA_IN_PORT,
    output logic                 DATA_VALID,
    output logic                 HMASTLOCKM
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_TRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_TRANS_SEQ    = 2'b11;

    localparam logic [2:0] c_BURST_SINGLE = 3'b000;
    localparam logic [2:0] c_BURST_INCR   = 3'b001;
    localparam logic [2:0] c_BURST_WRAP4  = 3'b010;
    localparam logic [2:0] c_BURST_INCR4  = 3'b011;
    localparam logic [2:0] c_BURST_WRAP8  = 3'b100;
    localparam logic [2:0] c_BURST_INCR8  = 3'b101;
    localparam logic [2:0] c_BURST_WRAP16 = 3'b110;
    localparam logic [2:0] c_BURST_INCR16 = 3'b111;

    localparam int         c_CNT_W        = 4;
    localparam int         c_IDX_SPAN     = 2 ** IDX_W;
    // Last-grant pointer starts at the highest port so port 0 wins first.
    localparam logic [IDX_W-1:0] c_LAST_RESET = IDX_W'(NUM_PORTS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]   r_addr_port;
    logic               r_no_port;
    logic [IDX_W-1:0]   r_data_port;
    logic               r_data_valid;
    logic [IDX_W-1:0]   r_last_grant;
    logic [c_CNT_W-1:0] r_beat_cnt;

    // ------------------------------------------------------------------------
    // LOCK widened to the full index range so it can be indexed by any
    // IDX_W-bit value; unused codes read as unlocked.
    // ------------------------------------------------------------------------
    logic [c_IDX_SPAN-1:0] w_lock_ext;

    generate
        for (genvar gi = 0; gi < c_IDX_SPAN; gi++) begin : g_lock_ext
            if (gi < NUM_PORTS) begin : g_real
                assign w_lock_ext[gi] = LOCK[gi];
            end else begin : g_pad
                assign w_lock_ext[gi] = 1'b0;
            end
        end
    endgenerate

    logic w_owner_locked;
    assign w_owner_locked = ~r_no_port & w_lock_ext[r_addr_port];

    // ------------------------------------------------------------------------
    // Beat counter next value: remaining beats of the burst in progress
    // after the transfer currently on the bus has been accepted.
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_beat_cnt;
        case (HTRANSM)
            c_TRANS_IDLE: begin
                w_cnt_next = '0;
            end
            c_TRANS_BUSY: begin
                w_cnt_next = r_beat_cnt;
            end
            c_TRANS_NONSEQ: begin
                case (HBURSTM)
                    c_BURST_WRAP4,  c_BURST_INCR4:  w_cnt_next = 4'd3;
                    c_BURST_WRAP8,  c_BURST_INCR8:  w_cnt_next = 4'd7;
                    c_BURST_WRAP16, c_BURST_INCR16: w_cnt_next = 4'd15;
                    c_BURST_SINGLE, c_BURST_INCR:   w_cnt_next = 4'd0;
                    default:                        w_cnt_next = 4'd0;
                endcase
            end
            c_TRANS_SEQ: begin
                // Saturate at zero: a SEQ past the end of a fixed burst (or
                // during an INCR burst) must not wrap the counter.
                if (r_beat_cnt != '0) begin
                    w_cnt_next = r_beat_cnt - 1'b1;
                end else begin
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_cnt_next = r_beat_cnt;
            end
        endcase
    end

    // Ownership is frozen while the owner is locked, while a fixed-length
    // burst still has beats left, or while an INCR burst is paused in BUSY.
    logic w_hold;
    assign w_hold = w_owner_locked
                  | (w_cnt_next != '0)
                  | ((HTRANSM == c_TRANS_BUSY) && (HBURSTM == c_BURST_INCR));

    // ------------------------------------------------------------------------
    // Round-robin search. Each requester gets a priority distance from the
    // port after the last grant; the smallest distance wins. The distance is
    // (j - last_grant - 1) mod NUM_PORTS, formed with one conditional
    // subtract instead of a divider.
    // ------------------------------------------------------------------------
    logic             w_grant_valid;
    logic [IDX_W-1:0] w_grant_idx;
    int               w_dist;
    int               w_best_dist;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_dist        = 0;
        w_best_dist   = NUM_PORTS;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_dist = j + NUM_PORTS - 1 - int'(r_last_grant);
            if (w_dist >= NUM_PORTS) begin
                w_dist = w_dist - NUM_PORTS;
            end
            if (REQ[j] && (w_dist < w_best_dist)) begin
                w_best_dist   = w_dist;
                w_grant_idx   = IDX_W'(j);
                w_grant_valid = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers. Nothing moves unless the slave accepts the address phase,
    // so the grant never changes in the middle of a wait state. The data
    // phase registers capture the address-phase owner on the same edge the
    // address ownership is re-decided.
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_addr_port  <= '0;
            r_no_port    <= 1'b1;
            r_data_port  <= '0;
            r_data_valid <= 1'b0;
            r_last_grant <= c_LAST_RESET;
            r_beat_cnt   <= '0;
        end else if (HREADYM) begin
            r_beat_cnt   <= w_cnt_next;
            r_data_port  <= r_addr_port;
            r_data_valid <= ~r_no_port & HTRANSM[1];
            if (!w_hold) begin
                if (w_grant_valid) begin
                    r_addr_port  <= w_grant_idx;
                    r_no_port    <= 1'b0;
                    r_last_grant <= w_grant_idx;
                end else begin
                    // Nobody requesting: park on the previous owner so the
                    // mux select is stable, but mark the stage as unowned.
                    r_no_port    <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ADDR_IN_PORT = r_addr_port;
    assign NO_PORT      = r_no_port;
    assign DATA_IN_PORT = r_data_port;
    assign DATA_VALID   = r_data_valid;
    assign HMASTLOCKM   = w_owner_locked;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_matrix_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bus_matrix_arbiter
// Description : Self-checking bench for ahb_bus_matrix_arbiter. A driver
//               applies one input vector per clock, advances a behavioural
//               reference model and queues the expected outputs; a monitor
//               pops one expectation after every rising edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_bus_matrix_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [N-1:0]  REQ = '0;
    logic [N-1:0]  LOCK = '0;
    logic [1:0]    HTRANSM = IDLE;
    logic [2:0]    HBURSTM = SINGLE;
    logic          HREADYM = 1'b1;
    logic [IW-1:0] ADDR_IN_PORT;
    logic          NO_PORT;
    logic [IW-1:0] DATA_IN_PORT;
    logic          DATA_VALID;
    logic          HMASTLOCKM;

    ahb_bus_matrix_arbiter #(
        .NUM_PORTS (N),
        .IDX_W     (IW)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .REQ          (REQ),
        .LOCK         (LOCK),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HREADYM      (HREADYM),
        .ADDR_IN_PORT (ADDR_IN_PORT),
        .NO_PORT      (NO_PORT),
        .DATA_IN_PORT (DATA_IN_PORT),
        .DATA_VALID   (DATA_VALID),
        .HMASTLOCKM   (HMASTLOCKM)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int addr;
        int no;
        int data;
        int dv;
        int lk;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model state ----------------
    int m_addr, m_no, m_data, m_dv, m_last, m_remaining;

    function automatic int beats_of(input logic [2:0] b);
        if (b >= 3'd6)      return 16;
        else if (b >= 3'd4) return 8;
        else if (b >= 3'd2) return 4;
        else                return 1;
    endfunction

    // One clock of stimulus: drive inputs, advance model, queue expectation.
    task automatic step(input bit rst, input logic [N-1:0] req, input logic [N-1:0] lock,
                        input logic [1:0] tr, input logic [2:0] bu, input bit rdy);
        int   rem_new;
        bit   held;
        int   winner;
        int   p;
        exp_t e;
        @(negedge HCLK);
        HRESET  = rst;
        REQ     = req;
        LOCK    = lock;
        HTRANSM = tr;
        HBURSTM = bu;
        HREADYM = rdy;
        if (rst) begin
            m_addr = 0; m_no = 1; m_data = 0; m_dv = 0;
            m_last = N - 1; m_remaining = 0;
        end else if (rdy) begin
            case (tr)
                IDLE:    rem_new = 0;
                BUSY:    rem_new = m_remaining;
                NONSEQ:  rem_new = beats_of(bu) - 1;
                default: rem_new = (m_remaining > 0) ? m_remaining - 1 : 0;
            endcase
            held = (m_no == 0 && lock[m_addr] == 1'b1) || (rem_new != 0) ||
                   (tr == BUSY && bu == INCR);
            m_data = m_addr;
            m_dv   = (m_no == 0 && tr[1] == 1'b1) ? 1 : 0;
            m_remaining = rem_new;
            if (!held) begin
                winner = -1;
                for (int off = 1; off <= N; off++) begin
                    p = (m_last + off) % N;
                    if (winner < 0 && req[p]) winner = p;
                end
                if (winner >= 0) begin
                    m_addr = winner; m_no = 0; m_last = winner;
                end else begin
                    m_no = 1;
                end
            end
        end
        e.addr = m_addr;
        e.no   = m_no;
        e.data = m_data;
        e.dv   = m_dv;
        e.lk   = (m_no == 0 && lock[m_addr] == 1'b1) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge HCLK) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("ADDR_IN_PORT", int'(ADDR_IN_PORT), mon_e.addr);
            chk("NO_PORT",      int'(NO_PORT),      mon_e.no);
            chk("DATA_IN_PORT", int'(DATA_IN_PORT), mon_e.data);
            chk("DATA_VALID",   int'(DATA_VALID),   mon_e.dv);
            chk("HMASTLOCKM",   int'(HMASTLOCKM),   mon_e.lk);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        logic [N-1:0] rl;
        logic [N-1:0] rlk;

        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1);
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 0);

        // First grant after reset and its data phase
        step(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 1);
        step(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 1);

        // Rotation with a three-cycle wait state in the middle
        step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1);
        step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1);
        repeat (3) step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 0);
        repeat (4) step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1);

        // INCR4 from port 2 with competing requests and a wait state
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b1111, 4'b0000, NONSEQ, INCR4, 1);
        step(0, 4'b1111, 4'b0000, SEQ, INCR4, 1);
        step(0, 4'b1111, 4'b0000, SEQ, INCR4, 0);
        step(0, 4'b1111, 4'b0000, SEQ, INCR4, 1);
        step(0, 4'b1111, 4'b0000, SEQ, INCR4, 1);
        step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1);

        // Locked sequence from port 1, then lock drops
        step(0, 4'b0010, 4'b0010, IDLE, SINGLE, 1);
        repeat (3) step(0, 4'b1011, 4'b0010, NONSEQ, SINGLE, 1);
        step(0, 4'b1011, 4'b0000, NONSEQ, SINGLE, 1);
        step(0, 4'b1011, 4'b0000, NONSEQ, SINGLE, 1);

        // INCR burst paused in BUSY holds ownership
        step(0, 4'b1111, 4'b0000, NONSEQ, INCR, 1);
        step(0, 4'b1111, 4'b0000, BUSY, INCR, 1);
        step(0, 4'b1111, 4'b0000, SEQ, INCR, 1);

        // No requests: park
        step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1);

        // Early termination: owner drops REQ mid-burst, then IDLE
        step(0, 4'b0001, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b0001, 4'b0000, NONSEQ, INCR8, 1);
        step(0, 4'b0000, 4'b0000, SEQ, INCR8, 1);
        step(0, 4'b0100, 4'b0000, SEQ, INCR8, 1);
        step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 1);

        // Reset during beat 2 of INCR8 from port 3, inside a wait state
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b1000, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b1000, 4'b0000, NONSEQ, INCR8, 1);
        step(0, 4'b1000, 4'b0000, SEQ, INCR8, 0);
        step(1, 4'b1000, 4'b0000, SEQ, INCR8, 0);
        step(0, 4'b1001, 4'b0000, IDLE, SINGLE, 1);
        step(0, 4'b1001, 4'b0000, NONSEQ, SINGLE, 1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rl  = N'($urandom);
            rlk = N'($urandom) & N'($urandom) & N'($urandom);
            step(($urandom_range(0, 79) == 0), rl, rlk,
                 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge HCLK);
            guard++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
